// File: rtl/line_burst_adaptor_pkg.sv
// Shared widths, beat index and FSM state encoding for the line-to-burst adaptor.
package adaptor_types;

   localparam int ADDR_W         = 32;
   localparam int LINE_W         = 256;
   localparam int BURST_W        = 64;
   localparam int BEATS_PER_LINE = 4;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [LINE_W-1:0]  line_t;
   typedef logic [BURST_W-1:0] burst_t;
   typedef logic [1:0]         beat_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      DONE
   } adaptor_state_t;

   localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS_PER_LINE - 1);

   // Bursts always start on a 32-byte line boundary.
   function automatic addr_t align_line(input addr_t a);
      return {a[ADDR_W-1:5], 5'b0};
   endfunction

endpackage

// File: rtl/line_burst_adaptor.sv
// Splits 256-bit line reads/writes into four 64-bit bursts, one line_resp pulse per line.
// Min 6 cycles request-to-idle; burst_resp low stalls the FSM and beat counter in place.
module line_burst_adaptor
   import adaptor_types::*;
(
   input  logic   clk,
   input  logic   rst,
   input  addr_t  line_address,
   input  logic   line_read,
   input  logic   line_write,
   input  line_t  line_wdata,
   output line_t  line_rdata,
   output logic   line_resp,
   output addr_t  burst_address,
   output logic   burst_read,
   output logic   burst_write,
   output burst_t burst_wdata,
   input  burst_t burst_rdata,
   input  logic   burst_resp
);

   adaptor_state_t state, state_next;
   beat_idx_t      beat;
   line_t          wline;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         beat          <= '0;
         wline         <= '0;
         line_rdata    <= '0;
         burst_address <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               // Write wins when both requests are presented together.
               if (line_write) begin
                  wline         <= line_wdata;
                  burst_address <= align_line(line_address);
                  beat          <= '0;
               end else if (line_read) begin
                  burst_address <= align_line(line_address);
                  beat          <= '0;
               end
            end
            RD: begin
               if (burst_resp) begin
                  line_rdata[int'(beat)*BURST_W +: BURST_W] <= burst_rdata;
                  beat <= beat + 2'd1;
               end
            end
            WR: begin
               if (burst_resp) begin
                  beat <= beat + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next  = state;
      line_resp   = 1'b0;
      burst_read  = 1'b0;
      burst_write = 1'b0;
      burst_wdata = '0;
      case (state)
         IDLE: begin
            if (line_write) begin
               state_next = WR;
            end else if (line_read) begin
               state_next = RD;
            end
         end
         RD: begin
            burst_read = 1'b1;
            if (burst_resp && beat == LAST_BEAT) begin
               state_next = DONE;
            end
         end
         WR: begin
            burst_write = 1'b1;
            burst_wdata = wline[int'(beat)*BURST_W +: BURST_W];
            if (burst_resp && beat == LAST_BEAT) begin
               state_next = DONE;
            end
         end
         DONE: begin
            line_resp  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: reads, writes, stalls, priority, back-to-back, mid-burst reset.
module tb_line_burst_adaptor;

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    line_address;
   logic           line_read;
   logic           line_write;
   logic [255:0]   line_wdata;
   logic [255:0]   line_rdata;
   logic           line_resp;
   logic [31:0]    burst_address;
   logic           burst_read;
   logic           burst_write;
   logic [63:0]    burst_wdata;
   logic [63:0]    burst_rdata;
   logic           burst_resp;

   int n_assert = 0;
   int n_fail   = 0;

   logic [63:0] beats [4];
   int          ncyc;

   line_burst_adaptor dut (
      .clk           (clk),
      .rst           (rst),
      .line_address  (line_address),
      .line_read     (line_read),
      .line_write    (line_write),
      .line_wdata    (line_wdata),
      .line_rdata    (line_rdata),
      .line_resp     (line_resp),
      .burst_address (burst_address),
      .burst_read    (burst_read),
      .burst_write   (burst_write),
      .burst_wdata   (burst_wdata),
      .burst_rdata   (burst_rdata),
      .burst_resp    (burst_resp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Raises line_read at the current (IDLE) cycle and feeds beats[] back, holding burst_resp
   // low for stall_n cycles just before beat index stall_at. Returns in the line_resp cycle.
   task automatic run_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input int stall_at, input int stall_n, output int cycles);
      int b = 0;
      int s = 0;
      line_read    = 1'b1;
      line_address = addr;
      cycles       = 1;
      step();
      cycles++;
      chk("rd_start", {255'd0, burst_read}, 256'd1);
      chk("rd_addr", {224'd0, burst_address}, {224'd0, exp_addr});
      while (line_resp !== 1'b1 && cycles < 40) begin
         chk("rd_busy", {254'd0, burst_read, burst_write}, 256'd2);
         if (b == stall_at && s < stall_n) begin
            burst_resp  = 1'b0;
            burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            s++;
         end else begin
            burst_resp  = 1'b1;
            burst_rdata = beats[b < 4 ? b : 3];
            b++;
         end
         step();
         cycles++;
      end
      burst_resp = 1'b0;
      chk("rd_resp", {255'd0, line_resp}, 256'd1);
      chk("rd_released", {255'd0, burst_read}, 256'd0);
   endtask

   // Same shape for writes; checks the presented beat every WR cycle, stalls included.
   task automatic run_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic also_read, input int stall_at, input int stall_n,
                            output int cycles);
      int b = 0;
      int s = 0;
      line_write   = 1'b1;
      line_read    = also_read;
      line_address = addr;
      line_wdata   = {beats[3], beats[2], beats[1], beats[0]};
      cycles       = 1;
      step();
      cycles++;
      chk("wr_addr", {224'd0, burst_address}, {224'd0, exp_addr});
      while (line_resp !== 1'b1 && cycles < 40) begin
         chk("wr_busy", {254'd0, burst_read, burst_write}, 256'd1);
         chk("wr_beat", {192'd0, burst_wdata}, {192'd0, beats[b < 4 ? b : 3]});
         if (b == stall_at && s < stall_n) begin
            burst_resp = 1'b0;
            s++;
         end else begin
            burst_resp = 1'b1;
            b++;
         end
         // Line data is latched at request time; scribbling it here must not matter.
         line_wdata = ~line_wdata;
         step();
         cycles++;
      end
      burst_resp = 1'b0;
      chk("wr_resp", {255'd0, line_resp}, 256'd1);
      chk("wr_released", {254'd0, burst_read, burst_write}, 256'd0);
   endtask

   task automatic drop_and_idle();
      line_read  = 1'b0;
      line_write = 1'b0;
      step();
      chk("resp_single", {255'd0, line_resp}, 256'd0);
   endtask

   initial begin
      rst          = 1'b1;
      line_address = '0;
      line_read    = 1'b0;
      line_write   = 1'b0;
      line_wdata   = '0;
      burst_rdata  = '0;
      burst_resp   = 1'b0;
      step();
      step();

      chk("rst_rdata", line_rdata, 256'd0);
      chk("rst_ctrl", {253'd0, line_resp, burst_read, burst_write}, 256'd0);
      chk("rst_addr", {224'd0, burst_address}, 256'd0);
      chk("rst_wdata", {192'd0, burst_wdata}, 256'd0);
      rst = 1'b0;
      // burst_resp while idle must be ignored.
      burst_resp  = 1'b1;
      burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      burst_resp = 1'b0;
      step();
      chk("idle_ignore", line_rdata, 256'd0);

      // Plain read, no stalls.
      beats[0] = 64'h1111_1111_1111_1111;
      beats[1] = 64'h2222_2222_2222_2222;
      beats[2] = 64'h3333_3333_3333_3333;
      beats[3] = 64'h4444_4444_4444_4444;
      run_read(32'h0000_1234, 32'h0000_1220, 9, 0, ncyc);
      chk("rd_latency", 256'(ncyc), 256'd6);
      chk("rd_line", line_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      drop_and_idle();
      chk("rd_hold", line_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      chk("addr_hold", {224'd0, burst_address}, 256'h1220);

      // Plain write.
      beats[0] = 64'hAAAA_0000_AAAA_0000;
      beats[1] = 64'hBBBB_1111_BBBB_1111;
      beats[2] = 64'hCCCC_2222_CCCC_2222;
      beats[3] = 64'hDDDD_3333_DDDD_3333;
      run_write(32'hDEAD_BEEF, 32'hDEAD_BEE0, 1'b0, 9, 0, ncyc);
      chk("wr_latency", 256'(ncyc), 256'd6);
      drop_and_idle();
      chk("wr_idle_wdata", {192'd0, burst_wdata}, 256'd0);

      // Read with 3 stall cycles between beats 1 and 2.
      beats[0] = 64'h0123_4567_89AB_CDEF;
      beats[1] = 64'hFEDC_BA98_7654_3210;
      beats[2] = 64'h5A5A_5A5A_A5A5_A5A5;
      beats[3] = 64'h0F0F_F0F0_0F0F_F0F0;
      run_read(32'h8000_003F, 32'h8000_0020, 2, 3, ncyc);
      chk("stall_latency", 256'(ncyc), 256'd9);
      chk("stall_line", line_rdata, {64'h0F0F_F0F0_0F0F_F0F0, 64'h5A5A_5A5A_A5A5_A5A5,
                                     64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
      drop_and_idle();

      // Both requests together: write taken, burst_read never seen (checked every cycle),
      // and a stalled write beat stays on the bus.
      beats[0] = 64'h1000_0000_0000_0001;
      beats[1] = 64'h2000_0000_0000_0002;
      beats[2] = 64'h3000_0000_0000_0003;
      beats[3] = 64'h4000_0000_0000_0004;
      run_write(32'h0000_0040, 32'h0000_0040, 1'b1, 3, 2, ncyc);
      chk("both_latency", 256'(ncyc), 256'd8);
      chk("both_rdata_kept", line_rdata, {64'h0F0F_F0F0_0F0F_F0F0, 64'h5A5A_5A5A_A5A5_A5A5,
                                          64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});

      // Back-to-back: read asserted as the write completes, ignored in DONE,
      // sampled on return to IDLE, burst starting the cycle after.
      line_write = 1'b0;
      line_read  = 1'b1;
      step();
      chk("b2b_idle", {253'd0, line_resp, burst_read, burst_write}, 256'd0);
      beats[0] = 64'hC0DE_0000_0000_0000;
      beats[1] = 64'hC0DE_1111_0000_0000;
      beats[2] = 64'hC0DE_2222_0000_0000;
      beats[3] = 64'hC0DE_3333_0000_0000;
      run_read(32'h0000_0040, 32'h0000_0040, 9, 0, ncyc);
      chk("b2b_latency", 256'(ncyc), 256'd6);
      chk("b2b_line", line_rdata, {64'hC0DE_3333_0000_0000, 64'hC0DE_2222_0000_0000,
                                   64'hC0DE_1111_0000_0000, 64'hC0DE_0000_0000_0000});
      drop_and_idle();

      // Reset after beat 2 of a read.
      line_read    = 1'b1;
      line_address = 32'h0000_2000;
      step();
      for (int i = 0; i < 3; i++) begin
         burst_resp  = 1'b1;
         burst_rdata = 64'hEEEE_0000_0000_0000 | 64'(i);
         step();
      end
      burst_resp = 1'b0;
      line_read  = 1'b0;
      rst        = 1'b1;
      step();
      chk("mid_rst_rdata", line_rdata, 256'd0);
      chk("mid_rst_ctrl", {253'd0, line_resp, burst_read, burst_write}, 256'd0);
      chk("mid_rst_addr", {224'd0, burst_address}, 256'd0);
      rst = 1'b0;
      step();
      beats[0] = 64'h7777_0000_0000_0007;
      beats[1] = 64'h7777_0000_0000_0017;
      beats[2] = 64'h7777_0000_0000_0027;
      beats[3] = 64'h7777_0000_0000_0037;
      run_read(32'h0000_3001, 32'h0000_3000, 9, 0, ncyc);
      chk("post_rst_latency", 256'(ncyc), 256'd6);
      chk("post_rst_line", line_rdata, {64'h7777_0000_0000_0037, 64'h7777_0000_0000_0027,
                                        64'h7777_0000_0000_0017, 64'h7777_0000_0000_0007});
      drop_and_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/line_burst_adaptor.md
# line_burst_adaptor

Converts the single-line requests issued by the cache arbiter into 4-beat, 64-bit bursts on the physical-memory port. It sits directly downstream of the arbiter. On reads it assembles four returned beats into one 256-bit line. On writes it serialises a 256-bit line into four beats. It returns one single-cycle line-level response per transaction.

## Interface
- Parameters: none. Widths come from `adaptor_types` (`line_t` = 256 b, `burst_t` = 64 b, `addr_t` = 32 b, `BEATS_PER_LINE` = 4).
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `line_address`  in  32  line address from the arbiter (`cache_address`).
- `line_read`  in  1  line read request; held until `line_resp`.
- `line_write`  in  1  line write request; held until `line_resp`.
- `line_wdata`  in  256  line to write (`cache_to_pmem`); stable while `line_write` is high.
- `line_rdata`  out  256  assembled read line (`pmem_to_cache`).
- `line_resp`  out  1  one-cycle completion pulse (`cache_resp`).
- `burst_address`  out  32  burst base address, bits [4:0] forced to 0.
- `burst_read`  out  1  burst read request.
- `burst_write`  out  1  burst write request.
- `burst_wdata`  out  64  current write beat.
- `burst_rdata`  in  64  current read beat.
- `burst_resp`  in  1  beat handshake; high for each beat transferred.

## Operation
- States: `IDLE`, `RD`, `WR`, `DONE`. A 2-bit beat counter `beat` runs 0..3.
- **IDLE**
  - Sample the request.
  - `line_write` → latch `line_wdata` and the aligned address, set `beat`=0, go to `WR`.
  - Else `line_read` → latch the aligned address, set `beat`=0, go to `RD`.
  - Write has priority when both are high.
- **RD**
  - `burst_read`=1.
  - Each cycle with `burst_resp`=1: store `burst_rdata` into `line_rdata[64*beat +: 64]` and increment `beat`.
  - On the beat with `beat`==3: go to `DONE`.
- **WR**
  - `burst_write`=1 and `burst_wdata` = latched line slice `[64*beat +: 64]`.
  - Each `burst_resp` advances `beat`.
  - On the beat with `beat`==3: go to `DONE`.
- **DONE**
  - `line_resp`=1 for exactly one cycle, then go to `IDLE`.
  - Requests seen in `DONE` are ignored. Upstream drops its request in the same cycle it sees `line_resp`.
- Beat order is little-endian: beat 0 = line bits [63:0].
- `burst_address` = latched `{line_address[31:5], 5'b0}`. It is held for the whole transaction and keeps its last value in `IDLE`.
- `line_rdata` holds the last assembled line until the next read overwrites beats. It is valid when `line_resp` is high after a read.
- Cycles with `burst_resp`=0 inside `RD`/`WR` are stalls: no state or counter change.
- `burst_resp` while in `IDLE` or `DONE` is ignored.

## Timing
- Reset values: `line_rdata`=0, `line_resp`=0, `burst_address`=0, `burst_read`=0, `burst_write`=0, `burst_wdata`=0. State = `IDLE`, `beat`=0.
- Request sampled in cycle T (`IDLE`) → `burst_read`/`burst_write` high from T+1.
- Last beat in cycle L → `burst_read`/`burst_write` low and `line_resp` high in L+1. `IDLE` resumes at L+2.
- Minimum transaction with no stalls: 6 cycles from request to the cycle after `line_resp`.
- Back-to-back: a request held or re-asserted in `IDLE` at L+2 starts the next burst at L+3.
- Reset mid-burst: the next cycle is `IDLE` with all outputs at reset values and the partial line discarded (`line_rdata` cleared). The memory model is reset together with this block.
- No combinational path from any input to any output. All outputs are registered or decoded from state.

## Structure
- Add to `adaptor_types`:
  - `burst_t` (logic [63:0]).
  - `BEATS_PER_LINE` = 4.
  - `beat_idx_t` (logic [1:0]).
  - Adaptor state enum `{IDLE, RD, WR, DONE}`.
- Reuse `line_t` and `addr_t` from the existing packages.
- Single module, no sub-module. Counter, FSM and line shift/assembly registers all live in `line_burst_adaptor`.
- Integration: instantiate between the arbiter's pmem-side ports and the burst memory model.

## Test plan
- **Read line:** `line_read`, addr 0x0000_1234; memory returns beats 0x11.., 0x22.., 0x33.., 0x44.. → `burst_address`=0x0000_1220. `line_rdata` = {0x44..,0x33..,0x22..,0x11..}. `line_resp` is high 1 cycle, 6 cycles after request.
- **Write line:** `line_write`, `line_wdata` = 256'h{D,C,B,A} beats → `burst_wdata` presents A,B,C,D in order on successive `burst_resp`. `line_resp` pulses once, then `burst_write`=0.
- **Stalled burst:** read with `burst_resp` low for 3 cycles between beats 1 and 2 → beats land in the correct slices and `line_resp` is delayed by exactly 3 cycles.
- **Simultaneous request:** `line_read`=`line_write`=1 in `IDLE` → `WR` is taken and `burst_read` never asserts during that transaction.
- **Back-to-back:** write then read held continuously → two distinct `line_resp` pulses. The second burst starts 1 cycle after returning to `IDLE`.
- **Reset mid-read:** `rst` after beat 2 → all outputs 0 the next cycle. A fresh read then completes normally with correct data.
